// File: rtl/multi_cycle_control_unit_if.sv
// Control bundle between the multi-cycle control unit and the shared CPU datapath.
// The control unit is the master: it consumes opcode/zero and drives every enable and select.
interface multi_cycle_control_unit_if #(
    parameter int OP_W = 6,
    parameter int ST_W = 3
);
    logic [OP_W-1:0] opcode;
    logic            zero;
    logic [ST_W-1:0] state;
    logic            halted;
    logic            pcwre;
    logic            irwre;
    logic            regwre;
    logic            mrd;
    logic            mwr;
    logic            alusrca;
    logic            alusrcb;
    logic            dbdatasrc;
    logic            wrregdsrc;
    logic [1:0]      regdst;
    logic            extsel;
    logic [1:0]      pcsrc;
    logic [2:0]      aluop;

    modport master (
        input  opcode, zero,
        output state, halted, pcwre, irwre, regwre, mrd, mwr,
               alusrca, alusrcb, dbdatasrc, wrregdsrc, regdst, extsel, pcsrc, aluop
    );

    modport slave (
        output opcode, zero,
        input  state, halted, pcwre, irwre, regwre, mrd, mwr,
               alusrca, alusrcb, dbdatasrc, wrregdsrc, regdst, extsel, pcsrc, aluop
    );
endinterface

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle CPU controller: sequences IF/ID/EXE/MEM/WB phases and decodes the
// instruction-register opcode into datapath enables and mux selects.
module multi_cycle_control_unit #(
    parameter int OP_W = 6,
    parameter int ST_W = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    multi_cycle_control_unit_if.master    bus
);

    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(6'b000001);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(6'b010000);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(6'b010001);
    localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b010010);
    localparam logic [OP_W-1:0] OP_SLL  = OP_W'(6'b011000);
    localparam logic [OP_W-1:0] OP_SLT  = OP_W'(6'b100110);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b110000);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b110001);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b110100);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'b110101);
    localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b111000);
    localparam logic [OP_W-1:0] OP_JR   = OP_W'(6'b111001);
    localparam logic [OP_W-1:0] OP_JAL  = OP_W'(6'b111010);
    localparam logic [OP_W-1:0] OP_HALT = OP_W'(6'b111111);

    typedef enum logic [ST_W-1:0] {
        S_IF      = ST_W'(0),
        S_ID      = ST_W'(1),
        S_EXE_AL  = ST_W'(2),
        S_EXE_BR  = ST_W'(3),
        S_EXE_MEM = ST_W'(4),
        S_MEM     = ST_W'(5),
        S_WB_AL   = ST_W'(6),
        S_WB_LD   = ST_W'(7)
    } state_t;

    state_t state_reg, state_next;
    logic   halted_reg, halted_next;

    // Opcode classes; the IR is stable from ID onward so these are decoded combinationally.
    logic is_r, is_i, is_lw, is_sw, is_br, is_jmp, is_halt, br_taken;
    logic [2:0] op_aluop;
    logic [1:0] op_regdst;

    always_comb begin
        is_r     = bus.opcode inside {OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SLL, OP_SLT};
        is_i     = bus.opcode inside {OP_ADDI, OP_ORI};
        is_lw    = (bus.opcode == OP_LW);
        is_sw    = (bus.opcode == OP_SW);
        is_br    = bus.opcode inside {OP_BEQ, OP_BNE};
        is_jmp   = bus.opcode inside {OP_J, OP_JR, OP_JAL};
        is_halt  = (bus.opcode == OP_HALT);
        br_taken = ((bus.opcode == OP_BEQ) && bus.zero) || ((bus.opcode == OP_BNE) && !bus.zero);

        op_aluop = 3'b000;
        case (bus.opcode)
            OP_SUB, OP_BEQ, OP_BNE: op_aluop = 3'b001;
            OP_SLL:                 op_aluop = 3'b010;
            OP_OR, OP_ORI:          op_aluop = 3'b011;
            OP_AND:                 op_aluop = 3'b100;
            OP_SLT:                 op_aluop = 3'b101;
            default:                op_aluop = 3'b000;
        endcase

        op_regdst = 2'b00;
        if (is_r)
            op_regdst = 2'b10;
        else if (is_i || is_lw)
            op_regdst = 2'b01;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IF;
            halted_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            halted_reg <= halted_next;
        end
    end

    logic       pcwre_c, irwre_c, regwre_c, mrd_c, mwr_c;
    logic       alusrca_c, alusrcb_c, dbdatasrc_c, wrregdsrc_c, extsel_c;
    logic [1:0] regdst_c, pcsrc_c;
    logic [2:0] aluop_c;

    always_comb begin
        state_next  = state_reg;
        halted_next = halted_reg;
        pcwre_c     = 1'b0;
        irwre_c     = 1'b0;
        regwre_c    = 1'b0;
        mrd_c       = 1'b0;
        mwr_c       = 1'b0;
        alusrca_c   = 1'b0;
        alusrcb_c   = 1'b0;
        dbdatasrc_c = 1'b0;
        wrregdsrc_c = 1'b0;
        extsel_c    = 1'b0;
        regdst_c    = 2'b00;
        pcsrc_c     = 2'b00;
        aluop_c     = 3'b000;

        if (halted_reg) begin
            // Halt parks the state register at IF with every output idle.
            state_next = S_IF;
        end else begin
            if (state_reg != S_IF) begin
                extsel_c    = (bus.opcode != OP_ORI);
                alusrca_c   = (bus.opcode == OP_SLL);
                alusrcb_c   = is_i || is_lw || is_sw;
                wrregdsrc_c = (bus.opcode != OP_JAL);
                regdst_c    = op_regdst;
                aluop_c     = op_aluop;
            end

            case (state_reg)
                S_IF: begin
                    irwre_c    = 1'b1;
                    state_next = S_ID;
                end
                S_ID: begin
                    if (is_jmp) begin
                        pcwre_c    = 1'b1;
                        pcsrc_c    = (bus.opcode == OP_JR) ? 2'b10 : 2'b11;
                        regwre_c   = (bus.opcode == OP_JAL);
                        state_next = S_IF;
                    end else if (is_halt) begin
                        halted_next = 1'b1;
                        state_next  = S_IF;
                    end else if (is_br) begin
                        state_next = S_EXE_BR;
                    end else if (is_lw || is_sw) begin
                        state_next = S_EXE_MEM;
                    end else if (is_r || is_i) begin
                        state_next = S_EXE_AL;
                    end else begin
                        pcwre_c    = 1'b1;
                        state_next = S_IF;
                    end
                end
                S_EXE_AL: state_next = S_WB_AL;
                S_WB_AL: begin
                    regwre_c   = 1'b1;
                    pcwre_c    = 1'b1;
                    state_next = S_IF;
                end
                S_EXE_BR: begin
                    pcwre_c    = 1'b1;
                    pcsrc_c    = br_taken ? 2'b01 : 2'b00;
                    state_next = S_IF;
                end
                S_EXE_MEM: state_next = S_MEM;
                S_MEM: begin
                    if (is_sw) begin
                        mwr_c      = 1'b1;
                        pcwre_c    = 1'b1;
                        state_next = S_IF;
                    end else begin
                        mrd_c      = 1'b1;
                        state_next = S_WB_LD;
                    end
                end
                S_WB_LD: begin
                    regwre_c    = 1'b1;
                    dbdatasrc_c = 1'b1;
                    pcwre_c     = 1'b1;
                    state_next  = S_IF;
                end
                default: state_next = S_IF;
            endcase
        end
    end

    // Write enables are gated by reset so an interrupted instruction commits nothing.
    assign bus.state     = state_reg;
    assign bus.halted    = halted_reg;
    assign bus.pcwre     = pcwre_c  & rst_n;
    assign bus.irwre     = irwre_c  & rst_n;
    assign bus.regwre    = regwre_c & rst_n;
    assign bus.mrd       = mrd_c    & rst_n;
    assign bus.mwr       = mwr_c    & rst_n;
    assign bus.alusrca   = alusrca_c;
    assign bus.alusrcb   = alusrcb_c;
    assign bus.dbdatasrc = dbdatasrc_c;
    assign bus.wrregdsrc = wrregdsrc_c;
    assign bus.extsel    = extsel_c;
    assign bus.regdst    = regdst_c;
    assign bus.pcsrc     = pcsrc_c;
    assign bus.aluop     = aluop_c;

endmodule
